// File: rtl/booth_pkg.sv
// Shared definitions for the Booth radix-2 multiplier controller.
package booth_pkg;

  // Operand width; also the datapath counter load value and the shift limit.
  localparam int BOOTH_WIDTH = 16;

  // Controller states. The encoding is fixed so it can be observed on a debug port.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_Q = 3'd1,
    EVAL  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } booth_state_e;

  // addsub strobe polarity seen by the datapath ALU.
  localparam logic ALU_SUB = 1'b0;
  localparam logic ALU_ADD = 1'b1;

endpackage

// File: rtl/booth_ctrl.sv
// Sequencing controller for the 16-bit Booth radix-2 multiplier datapath.
// Two operand beats on data_in (multiplicand, then multiplier), WIDTH Booth
// iterations, then the product {A,Q} is offered with a valid/ready handshake.
//
// Handshake: an operand beat transfers on a cycle where in_valid && in_ready;
// the product transfers on a cycle where out_valid && out_ready. out_valid
// holds steady until taken, and err qualifies the transfer when out_valid=1.
module booth_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic       abort,
  output logic       busy,
  output logic       err,
  input  logic       q0,
  input  logic       qm1,
  input  logic       eqz,
  output logic       lda,
  output logic       ldq,
  output logic       ldm,
  output logic       clra,
  output logic       clrq,
  output logic       clrff,
  output logic       sfta,
  output logic       sftq,
  output logic       addsub,
  output logic       decr,
  output logic       ldcnt,
  output logic [2:0] state_o
);

  localparam int IW = $clog2(WIDTH + 1);
  localparam logic [IW-1:0] ITER_MAX = IW'(WIDTH);
  localparam logic [IW-1:0] ITER_ONE = IW'(1);

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_GET_Q = GET_Q;
  localparam logic [2:0] ST_EVAL  = EVAL;
  localparam logic [2:0] ST_SHIFT = SHIFT;
  localparam logic [2:0] ST_DONE  = DONE;
  localparam logic [2:0] ST_ERR   = ERR;

  logic [2:0]    state_q, state_d;
  logic [IW-1:0] iter_q, iter_d;
  logic [IW-1:0] iter_inc;

  // Shift count saturates so a stuck counter cannot wrap the watchdog.
  assign iter_inc = (iter_q == ITER_MAX) ? iter_q : iter_q + ITER_ONE;

  assign busy    = (state_q == ST_EVAL) || (state_q == ST_SHIFT);
  assign state_o = state_q;

  // Next-state and strobe decode; abort overrides everything outside IDLE.
  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    err       = 1'b0;
    lda       = 1'b0;
    ldq       = 1'b0;
    ldm       = 1'b0;
    clra      = 1'b0;
    clrq      = 1'b0;
    clrff     = 1'b0;
    sfta      = 1'b0;
    sftq      = 1'b0;
    addsub    = ALU_SUB;
    decr      = 1'b0;
    ldcnt     = 1'b0;

    if (abort && (state_q != ST_IDLE)) begin
      clra    = 1'b1;
      clrq    = 1'b1;
      clrff   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          in_ready = 1'b1;
          if (in_valid) begin
            ldm     = 1'b1;
            state_d = ST_GET_Q;
          end
        end
        ST_GET_Q: begin
          in_ready = 1'b1;
          if (in_valid) begin
            ldq     = 1'b1;
            clra    = 1'b1;
            clrff   = 1'b1;
            ldcnt   = 1'b1;
            iter_d  = '0;
            state_d = ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (eqz) begin
            state_d = ST_DONE;
          end else if (iter_q == ITER_MAX) begin
            // Counter never reached zero after WIDTH shifts: datapath is stuck.
            state_d = ST_ERR;
          end else if ({q0, qm1} == 2'b10) begin
            lda     = 1'b1;
            addsub  = ALU_SUB;
            state_d = ST_SHIFT;
          end else if ({q0, qm1} == 2'b01) begin
            lda     = 1'b1;
            addsub  = ALU_ADD;
            state_d = ST_SHIFT;
          end else begin
            sfta   = 1'b1;
            sftq   = 1'b1;
            decr   = 1'b1;
            iter_d = iter_inc;
          end
        end
        ST_SHIFT: begin
          sfta    = 1'b1;
          sftq    = 1'b1;
          decr    = 1'b1;
          iter_d  = iter_inc;
          state_d = ST_EVAL;
        end
        ST_DONE: begin
          out_valid = 1'b1;
          if (out_ready) state_d = ST_IDLE;
        end
        ST_ERR: begin
          out_valid = 1'b1;
          err       = 1'b1;
          if (out_ready) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and iteration registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
    end
  end

endmodule

// File: tb/tb_booth_ctrl.sv
// Bench for booth_ctrl: drives operand beats, closes the loop through a
// behavioural Booth datapath, and checks product, latency and strobe counts
// against results computed directly from signed multiplication and the
// Booth recoding rule.
module tb_booth_ctrl;
  import booth_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, abort, busy, err;
  logic        q0, qm1, eqz;
  logic        lda, ldq, ldm, clra, clrq, clrff, sfta, sftq, addsub, decr, ldcnt;
  logic [2:0]  state_o;
  logic [15:0] data_in;
  logic        stuck_eqz;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] exp_q[$];

  // clock
  always #5 clk = ~clk;

  booth_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .abort(abort), .busy(busy),
    .err(err), .q0(q0), .qm1(qm1), .eqz(eqz), .lda(lda), .ldq(ldq), .ldm(ldm),
    .clra(clra), .clrq(clrq), .clrff(clrff), .sfta(sfta), .sftq(sftq),
    .addsub(addsub), .decr(decr), .ldcnt(ldcnt), .state_o(state_o)
  );

  logic [10:0] strobes;
  assign strobes = {lda, ldq, ldm, clra, clrq, clrff, sfta, sftq, addsub, decr, ldcnt};

  // Behavioural datapath. A carries a guard bit so the 0x8000 corner stays exact.
  logic [16:0] dp_a   = '0;
  logic [15:0] dp_q   = '0;
  logic [15:0] dp_m   = '0;
  logic        dp_qm1 = 1'b0;
  logic [4:0]  dp_cnt = '0;

  always @(posedge clk) begin
    if (ldm) dp_m <= data_in;
    if (clra) dp_a <= '0;
    else if (lda) dp_a <= addsub ? dp_a + {dp_m[15], dp_m} : dp_a - {dp_m[15], dp_m};
    else if (sfta) dp_a <= {dp_a[16], dp_a[16:1]};
    if (clrq) dp_q <= '0;
    else if (ldq) dp_q <= data_in;
    else if (sftq) dp_q <= {dp_a[0], dp_q[15:1]};
    dp_qm1 <= clrff ? 1'b0 : dp_q[0];
    if (ldcnt) dp_cnt <= 5'd16;
    else if (decr) dp_cnt <= dp_cnt - 5'd1;
  end

  assign q0  = dp_q[0];
  assign qm1 = dp_qm1;
  assign eqz = stuck_eqz ? 1'b0 : (dp_cnt == 5'd0);

  // Strobe activity counters.
  int   n_lda = 0, n_shift = 0, n_anysh = 0;
  logic as_log[$];

  always @(posedge clk) begin
    if (lda) begin
      n_lda++;
      as_log.push_back(addsub);
    end
    if (sfta && sftq && decr) n_shift++;
    if (sfta || sftq || decr) n_anysh++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Booth recoding of a multiplier: count of add/subtract steps.
  function automatic int n_arith(input logic [15:0] q);
    logic prev;
    int   n;
    prev = 1'b0;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (q[i] != prev) n++;
      prev = q[i];
    end
    return n;
  endfunction

  // Expected addsub sequence: 10 -> subtract (0), 01 -> add (1), packed in order.
  function automatic logic [15:0] exp_addsub(input logic [15:0] q);
    logic        prev;
    logic [15:0] w;
    int          k;
    prev = 1'b0;
    w = '0;
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (q[i] != prev) begin
        w[k] = prev;
        k++;
      end
      prev = q[i];
    end
    return w;
  endfunction

  task automatic send_operands(input logic [15:0] m, input logic [15:0] q);
    in_valid = 1'b1;
    data_in  = m;
    #1;
    chk("in_ready_idle", in_ready, 1);
    chk("ldm_pulse", ldm, 1);
    @(posedge clk); #1;
    data_in = q;
    chk("in_ready_getq", in_ready, 1);
    chk("getq_strobes", {ldq, clra, clrff, ldcnt}, 4'hF);
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = 16'($urandom);
  endtask

  task automatic wait_valid(output int edges);
    edges = 0;
    @(negedge clk);
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
  endtask

  task automatic take_output();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_state", state_o, IDLE);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);
  endtask

  task automatic do_op(input logic [15:0] m, input logic [15:0] q, input int hold);
    int          a, b, edges, lda0, sh0, any0, log0, na;
    logic [15:0] got_as;
    a = $signed(m);
    b = $signed(q);
    exp_q.push_back(32'(a * b));
    na = n_arith(q);
    send_operands(m, q);
    lda0 = n_lda; sh0 = n_shift; any0 = n_anysh; log0 = as_log.size();
    wait_valid(edges);
    chk("out_valid", out_valid, 1);
    chk("latency", edges, 17 + na);
    chk("product", {dp_a[15:0], dp_q}, exp_q.pop_front());
    chk("err_clear", err, 0);
    chk("lda_count", n_lda - lda0, na);
    chk("shift_count", n_shift - sh0, 16);
    chk("anyshift_count", n_anysh - any0, 16);
    got_as = '0;
    for (int i = log0; i < as_log.size() && (i - log0) < 16; i++) got_as[i - log0] = as_log[i];
    chk("addsub_seq", got_as, exp_addsub(q));
    repeat (hold) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_strobes", strobes, 0);
      chk("hold_in_ready", in_ready, 0);
    end
    take_output();
  endtask

  // Global time limit.
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          edges, sh0;
    logic [15:0] rm, rq;
    in_valid  = 1'b0;
    data_in   = '0;
    out_ready = 1'b0;
    abort     = 1'b0;
    stuck_eqz = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_state", state_o, IDLE);
    chk("rst_strobes", strobes, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    // directed operands
    do_op(16'h0003, 16'hFFFE, 0);
    do_op(16'h1234, 16'h0000, 0);
    do_op(16'h8000, 16'h8000, 0);
    do_op(16'h0007, 16'h5555, 0);
    do_op(16'h0003, 16'hFFFE, 5);

    // abort part-way through the iterations
    send_operands(16'h1234, 16'h5555);
    repeat (6) @(posedge clk);
    #1;
    abort = 1'b1;
    #1;
    chk("abort_clears", {clra, clrq, clrff}, 3'b111);
    chk("abort_others", {lda, ldq, ldm, sfta, sftq, decr, ldcnt}, 0);
    chk("abort_out_valid", out_valid, 0);
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_idle", state_o, IDLE);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    @(negedge clk);
    do_op(16'h0003, 16'hFFFE, 1);

    // stuck counter: watchdog after WIDTH shifts
    stuck_eqz = 1'b1;
    send_operands(16'h0005, 16'h0000);
    sh0 = n_shift;
    wait_valid(edges);
    chk("wd_out_valid", out_valid, 1);
    chk("wd_err", err, 1);
    chk("wd_state", state_o, ERR);
    chk("wd_latency", edges, 17);
    chk("wd_shifts", n_shift - sh0, 16);
    stuck_eqz = 1'b0;
    take_output();

    // asynchronous reset while in SHIFT
    send_operands(16'h0007, 16'h5555);
    @(posedge clk); #2;
    chk("pre_rst_shift", state_o, SHIFT);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_state", state_o, IDLE);
    chk("async_rst_strobes", strobes, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;

    // randomized operands
    for (int i = 0; i < 12; i++) begin
      rm = 16'($urandom);
      rq = 16'($urandom);
      case ($urandom_range(0, 5))
        0: rq = 16'h0000;
        1: rq = 16'hFFFF;
        2: rm = 16'h8000;
        default: ;
      endcase
      do_op(rm, rq, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
